// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe
//   Two-stage pipelined bitwise logic unit with valid/ready handshaking on
//   both sides, an accumulator for chained operations and a saturating
//   count of consumed result beats.
//
// Parameters
//   WIDTH     operand/result width
//   CNT_W     width of the beat counter
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   producer offers a beat
//   in_ready   unit accepts a beat this cycle (combinational from out_ready)
//   a, b       operands
//   op         000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR,
//              110 NOT a, 111 PASS a
//   mode       00/11 plain, 01 chain start, 10 chain continue (b <- acc)
//   out_valid  result beat present
//   out_ready  consumer takes the result this cycle
//   y          registered result
//   y_zero     y == 0
//   y_parity   XOR-reduction of y
//   beat_cnt   saturating count of consumed result beats

module bitwise_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_parity,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic [1:0]       s1_mode;
  logic             s2_valid;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] result;
  logic             s2_free;
  logic             accept;
  logic             transfer;

  // S2 can take a new beat when empty or when its current beat leaves now.
  // S1 then always frees up whenever it is occupied, so in_ready reduces to
  // !s1_valid || !s2_valid || out_ready.
  assign s2_free   = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_free;
  assign accept    = in_valid && in_ready;
  assign transfer  = s1_valid && s2_free;
  assign out_valid = s2_valid;

  // Chain-continue beats take the running accumulator in place of b.
  assign b_eff = (s1_mode == 2'b10) ? acc : s1_b;

  // The logic function itself, evaluated on the S1 contents.
  always_comb begin
    result = s1_a;
    case (s1_op)
      3'b000: result = s1_a & b_eff;
      3'b001: result = s1_a | b_eff;
      3'b010: result = s1_a ^ b_eff;
      3'b011: result = ~(s1_a & b_eff);
      3'b100: result = ~(s1_a | b_eff);
      3'b101: result = ~(s1_a ^ b_eff);
      3'b110: result = ~s1_a;
      3'b111: result = s1_a;
    endcase
  end

  // Stage 1 captures the raw beat. A simultaneous accept and transfer just
  // overwrites the outgoing contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_mode  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= a;
      s1_b     <= b;
      s1_op    <= op;
      s1_mode  <= mode;
    end else if (transfer) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 holds the result and its flags; they stay frozen while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      y        <= '0;
      y_zero   <= 1'b0;
      y_parity <= 1'b0;
    end else if (transfer) begin
      s2_valid <= 1'b1;
      y        <= result;
      y_zero   <= (result == '0);
      y_parity <= ^result;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // The accumulator moves in the same edge as the transfer, so the next
  // chain beat sitting in S1 sees it without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (transfer && (s1_mode == 2'b01 || s1_mode == 2'b10)) begin
      acc <= result;
    end
  end

  // Saturating count of beats handed to the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (s2_valid && out_ready && beat_cnt != CNT_MAX) begin
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// tb_bitwise_logic_pipe
//   Drives two instances of bitwise_logic_pipe from one shared stimulus:
//   a narrow one (WIDTH=2, CNT_W=16) and a wide one (WIDTH=8, CNT_W=3).
//   Single-beat opcode and chain vectors come from a table; backpressure,
//   mid-stream reset and counter saturation are hand-written sequences.

module tb_bitwise_logic_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  a_in = 8'h00;
  logic [7:0]  b_in = 8'h00;
  logic [2:0]  op = 3'b000;
  logic [1:0]  mode = 2'b00;
  logic        out_ready = 1'b1;

  logic        in_ready_n, out_valid_n, y_zero_n, y_parity_n;
  logic [1:0]  y_n;
  logic [15:0] beat_cnt_n;
  logic        in_ready_w, out_valid_w, y_zero_w, y_parity_w;
  logic [7:0]  y_w;
  logic [2:0]  beat_cnt_w;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [1:0] mode;
    logic [7:0] exp_y;
    logic       exp_zero;
    logic       exp_parity;
    logic       wide;
  } vec_t;

  vec_t vecs[11];

  bitwise_logic_pipe #(.WIDTH(2), .CNT_W(16)) u_narrow (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_n),
    .a(a_in[1:0]), .b(b_in[1:0]), .op(op), .mode(mode),
    .out_valid(out_valid_n), .out_ready(out_ready),
    .y(y_n), .y_zero(y_zero_n), .y_parity(y_parity_n), .beat_cnt(beat_cnt_n)
  );

  bitwise_logic_pipe #(.WIDTH(8), .CNT_W(3)) u_wide (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a_in), .b(b_in), .op(op), .mode(mode),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .y(y_w), .y_zero(y_zero_w), .y_parity(y_parity_w), .beat_cnt(beat_cnt_w)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] va,
                               input logic [7:0] vb, input logic [2:0] vop,
                               input logic [1:0] vmode);
    in_valid = v;
    a_in     = va;
    b_in     = vb;
    op       = vop;
    mode     = vmode;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 2'b00);
    for (int i = 0; i < n; i++) stepClock();
  endtask

  task automatic pulseReset();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 2'b00);
    rst = 1'b1;
    stepClock();
    rst = 1'b0;
  endtask

  task automatic checkVec(input int i);
    if (vecs[i].wide) begin
      checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid_w), 32'd1);
      checkOutput($sformatf("vec%0d y", i), 32'(y_w), 32'(vecs[i].exp_y));
      checkOutput($sformatf("vec%0d y_zero", i), 32'(y_zero_w), 32'(vecs[i].exp_zero));
      checkOutput($sformatf("vec%0d y_parity", i), 32'(y_parity_w), 32'(vecs[i].exp_parity));
    end else begin
      checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid_n), 32'd1);
      checkOutput($sformatf("vec%0d y", i), 32'(y_n), 32'(vecs[i].exp_y[1:0]));
      checkOutput($sformatf("vec%0d y_zero", i), 32'(y_zero_n), 32'(vecs[i].exp_zero));
      checkOutput($sformatf("vec%0d y_parity", i), 32'(y_parity_n), 32'(vecs[i].exp_parity));
    end
  endtask

  // Back-to-back beats; each result is checked two edges after it is driven.
  task automatic runTable(input int first, input int count);
    for (int c = 0; c <= count; c++) begin
      if (c < count)
        applyStimulus(1'b1, vecs[first+c].a, vecs[first+c].b,
                      vecs[first+c].op, vecs[first+c].mode);
      else
        applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 2'b00);
      stepClock();
      if (c >= 1) checkVec(first + c - 1);
    end
  endtask

  initial begin
    int idx;
    int rcv;

    // Opcode sweep on the narrow unit: a=01, b=10.
    vecs[0]  = '{8'h01, 8'h02, 3'b000, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8'h01, 8'h02, 3'b001, 2'b00, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'h01, 8'h02, 3'b010, 2'b00, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h01, 8'h02, 3'b011, 2'b00, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{8'h01, 8'h02, 3'b100, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{8'h01, 8'h02, 3'b101, 2'b00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'h01, 8'h02, 3'b110, 2'b00, 8'h02, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{8'h01, 8'h02, 3'b111, 2'b00, 8'h01, 1'b0, 1'b1, 1'b0};
    // XOR chain on the wide unit.
    vecs[8]  = '{8'h0F, 8'hF0, 3'b010, 2'b01, 8'hFF, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{8'h01, 8'h00, 3'b010, 2'b10, 8'hFE, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{8'h02, 8'h00, 3'b010, 2'b10, 8'hFC, 1'b0, 1'b0, 1'b1};

    // Reset held two cycles with in_valid high.
    $display("[TB] reset");
    applyStimulus(1'b1, 8'h01, 8'h02, 3'b111, 2'b00);
    rst = 1'b1;
    out_ready = 1'b1;
    stepClock();
    stepClock();
    checkOutput("rst out_valid", 32'(out_valid_n), 32'd0);
    checkOutput("rst y", 32'(y_n), 32'd0);
    checkOutput("rst y_zero", 32'(y_zero_n), 32'd0);
    checkOutput("rst y_parity", 32'(y_parity_n), 32'd0);
    checkOutput("rst beat_cnt", 32'(beat_cnt_n), 32'd0);
    checkOutput("rst wide out_valid", 32'(out_valid_w), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 2'b00);
    #1;
    checkOutput("post-rst in_ready", 32'(in_ready_n), 32'd1);
    checkOutput("post-rst wide in_ready", 32'(in_ready_w), 32'd1);
    stepClock();
    checkOutput("post-rst no beat", 32'(out_valid_n), 32'd0);

    // Opcode sweep, then one drain cycle.
    $display("[TB] opcode sweep");
    runTable(0, 8);
    stepClock();
    checkOutput("sweep idle out_valid", 32'(out_valid_n), 32'd0);
    checkOutput("sweep beat_cnt narrow", 32'(beat_cnt_n), 32'd8);
    checkOutput("sweep beat_cnt wide sat", 32'(beat_cnt_w), 32'd7);

    // Chain: FF, FE, FC.
    $display("[TB] chain");
    runTable(8, 3);
    stepClock();

    // Backpressure: consumer stalls for 5 cycles while 4 beats are offered.
    $display("[TB] backpressure");
    pulseReset();
    out_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      applyStimulus(1'b1, 8'(8'hA1 + idx), 8'h00, 3'b111, 2'b00);
      #1;
      checkOutput($sformatf("bp in_ready c%0d", cyc), 32'(in_ready_w),
                  (cyc < 2) ? 32'd1 : 32'd0);
      if (cyc >= 2) begin
        checkOutput($sformatf("bp stall out_valid c%0d", cyc), 32'(out_valid_w), 32'd1);
        checkOutput($sformatf("bp stall y c%0d", cyc), 32'(y_w), 32'hA1);
      end
      if (in_ready_w) idx++;
      stepClock();
    end
    checkOutput("bp accepted", 32'(idx), 32'd2);
    out_ready = 1'b1;
    rcv = 0;
    for (int cyc = 0; cyc < 12 && rcv < 4; cyc++) begin
      if (idx < 4) applyStimulus(1'b1, 8'(8'hA1 + idx), 8'h00, 3'b111, 2'b00);
      else         applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 2'b00);
      #1;
      if (out_valid_w) begin
        checkOutput($sformatf("bp order %0d", rcv), 32'(y_w), 32'(8'hA1 + rcv));
        rcv++;
      end
      if (in_valid && in_ready_w) idx++;
      stepClock();
    end
    checkOutput("bp received", 32'(rcv), 32'd4);
    checkOutput("bp beat_cnt", 32'(beat_cnt_w), 32'd4);
    checkOutput("bp beat_cnt narrow", 32'(beat_cnt_n), 32'd4);

    // Reset with two chain-start beats in flight.
    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 8'h33, 8'h00, 3'b010, 2'b01);
    stepClock();
    applyStimulus(1'b1, 8'h44, 8'h00, 3'b010, 2'b01);
    stepClock();
    checkOutput("mid in flight", 32'(out_valid_w), 32'd1);
    pulseReset();
    checkOutput("mid after rst out_valid", 32'(out_valid_w), 32'd0);
    checkOutput("mid after rst beat_cnt", 32'(beat_cnt_w), 32'd0);
    applyStimulus(1'b1, 8'h55, 8'hAA, 3'b010, 2'b10);
    stepClock();
    checkOutput("mid no ghost beat", 32'(out_valid_w), 32'd0);
    applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 2'b00);
    stepClock();
    checkOutput("mid acc cleared valid", 32'(out_valid_w), 32'd1);
    checkOutput("mid acc cleared y", 32'(y_w), 32'h55);
    checkOutput("mid acc cleared parity", 32'(y_parity_w), 32'd0);
    stepClock();
    checkOutput("mid beat_cnt", 32'(beat_cnt_w), 32'd1);

    // Counter saturation: 9 beats through a 3-bit counter.
    $display("[TB] saturation");
    pulseReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 8'(i), 8'h00, 3'b111, 2'b00);
      stepClock();
    end
    idleCycles(3);
    checkOutput("sat beat_cnt wide", 32'(beat_cnt_w), 32'd7);
    checkOutput("sat beat_cnt narrow", 32'(beat_cnt_n), 32'd9);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
